fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//   Parametrised successor to the single-register IF/ID pipeline stage. DEPTH-entry FIFO that
//   buffers {pc, instruction} pairs between fetch and decode, with valid/ready handshakes on both
//   sides. Flush on redirect (branch/jal/jalr). Emits a NOP bubble toward decode when empty.
// PARAMETERS
//   XLEN      32           width of pc
//   ILEN      32           width of instruction word
//   DEPTH     4            number of entries; power of two, >= 2
//   NOP_INSTR 32'h00000013 bubble word on deq_instr when empty (addi x0,x0,0)
// PORTS
//   clk        in  1                  single clock, rising edge
//   rst        in  1                  reset, synchronous, active-high
//   enq_valid  in  1                  fetch presents an instruction (instruc_mem_valid path)
//   enq_ready  out 1                  queue can accept; = !full
//   enq_pc     in  XLEN               pc of the fetched instruction
//   enq_instr  in  ILEN               fetched instruction word
//   deq_valid  out 1                  head entry valid; = !empty
//   deq_ready  in  1                  decode consumes head this cycle
//   deq_pc     out XLEN               pc of head entry; 0 when empty
//   deq_instr  out ILEN               head instruction; NOP_INSTR when empty
//   flush      in  1                  redirect: discard all entries
//   count      out $clog2(DEPTH+1)    current occupancy, 0..DEPTH
//   full       out 1                  count == DEPTH
//   empty      out 1                  count == 0
// BEHAVIOUR
//   - Reset (rst=1 at posedge): wr_ptr=rd_ptr=0, count=0; next cycle: empty=1, full=0,
//     enq_ready=1, deq_valid=0, deq_pc=0, deq_instr=NOP_INSTR. Storage contents not cleared.
//   - enq fire = enq_valid & enq_ready; deq fire = deq_valid & deq_ready.
//   - enq_ready depends only on registered state (no comb path from deq_ready); a full queue
//     refuses enq even when deq fires that cycle.
//   - enq fire: write {enq_pc,enq_instr} at wr_ptr, wr_ptr+=1 (mod DEPTH).
//   - deq fire: rd_ptr+=1 (mod DEPTH). Pointers are $clog2(DEPTH) bits, wrap naturally.
//   - count: +1 on enq only, -1 on deq only, unchanged on both or neither.
//   - Latency: entry enqueued at edge N is visible on deq_* after edge N (cycle N+1); no
//     same-cycle bypass from enq_* to deq_*.
//   - deq_pc/deq_instr read storage[rd_ptr] combinationally when !empty, else 0 / NOP_INSTR.
//   - deq_ready while empty: no effect. enq_valid while full: beat not accepted, fetch holds it.
//   - flush (priority over enq/deq, below rst): next edge wr_ptr=rd_ptr=count=0; any enq or deq
//     firing that cycle is discarded/ignored. enq_ready stays !full during flush cycle.
//   - flush and rst together: identical result to rst.
//   - FIFO order strictly preserved; no entry duplicated or lost except by flush.
// STRUCTURE
//   - Shared package riscv_pkg: XLEN, ILEN, NOP_INSTR constant, fetch_entry_t {pc, instr}.
//   - One sub-module: fetch_queue_mem (DEPTH x (XLEN+ILEN) register array, one sync write
//     port, one async read port, no reset). Pointer/count/flags logic in fetch_queue.
//   - Drop-in replacement for the IF/ID register in core; decode reads deq_pc/deq_instr.
// TESTING
//   1. Reset: rst=1 two cycles -> count=0, empty=1, enq_ready=1, deq_valid=0,
//      deq_instr=32'h00000013, deq_pc=0.
//   2. Fill, DEPTH=4, deq_ready=0: enq pc 0x0,0x4,0x8,0xC -> full=1, count=4, enq_ready=0;
//      5th enq_valid (pc 0x10) not accepted; deq_pc=0x0.
//   3. Drain in order: deq_ready=1 four cycles -> deq_pc 0x0,0x4,0x8,0xC over successive
//      cycles, then empty=1, deq_instr=NOP.
//   4. Wrap/simultaneous: 10 cycles enq_valid=deq_ready=1 from count=2 -> count holds 2, pc
//      sequence contiguous across pointer wrap, no gaps or duplicates.
//   5. Flush: count=3, flush=1 with enq_valid=1 (pc 0x40) -> next cycle count=0, empty=1,
//      0x40 absent; next enq pc 0x80 -> deq_pc=0x80 the following cycle.
//   6. Latency: empty queue, single enq pc 0x100 at edge N -> deq_valid=0 before edge N,
//      deq_valid=1 and deq_pc=0x100 after edge N.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core definitions: datapath widths, the bubble instruction and the
// fetch-to-decode payload.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    // addi x0,x0,0 -- handed to decode whenever there is nothing to issue
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage : riscv_pkg

// File: rtl/fetch_queue_mem.sv
// Storage array for fetch_queue: DEPTH x WIDTH registers, one synchronous
// write port, one asynchronous read port. Contents are never reset.
//   clk      in  1        rising-edge clock
//   wr_en    in  1        write wr_data into entry wr_addr at the edge
//   wr_addr  in  ADDR_W   write index
//   wr_data  in  WIDTH    write payload
//   rd_addr  in  ADDR_W   read index
//   rd_data  out WIDTH    contents of entry rd_addr (combinational)
module fetch_queue_mem #(
    parameter  int unsigned DEPTH  = 4,
    parameter  int unsigned WIDTH  = 64,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read port
    assign rd_data = mem_q[rd_addr];

endmodule : fetch_queue_mem

// File: rtl/fetch_queue.sv
// DEPTH-entry FIFO of {pc, instr} between fetch and decode, replacing the
// single IF/ID register. Valid/ready on both sides, flush on redirect, and a
// NOP bubble on the decode side while empty.
//   clk, rst                  clock, synchronous active-high reset
//   enq_valid/enq_ready       fetch handshake; enq_ready = !full
//   enq_pc, enq_instr         fetched pc and instruction word
//   deq_valid/deq_ready       decode handshake; deq_valid = !empty
//   deq_pc, deq_instr         head entry; 0 / NOP_INSTR when empty
//   flush                     drop every entry (redirect)
//   count, full, empty        occupancy and flags
module fetch_queue #(
    parameter  int unsigned     XLEN      = riscv_pkg::XLEN,
    parameter  int unsigned     ILEN      = riscv_pkg::ILEN,
    parameter  int unsigned     DEPTH     = 4,
    parameter  logic [ILEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR,
    localparam int unsigned     CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [XLEN-1:0]  enq_pc,
    input  logic [ILEN-1:0]  enq_instr,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [XLEN-1:0]  deq_pc,
    output logic [ILEN-1:0]  deq_instr,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned ENT_W = XLEN + ILEN;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             enq_fire;
    logic             deq_fire;
    logic             wr_en;
    logic [ENT_W-1:0] rd_data;

    // Flags come only from registered occupancy, so enq_ready has no path
    // from deq_ready: a full queue refuses even when the head leaves.
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign enq_ready = !full;
    assign deq_valid = !empty;
    assign count     = count_q;

    assign enq_fire = enq_valid & enq_ready;
    assign deq_fire = deq_valid & deq_ready;

    // A write under flush/reset would land in a slot the reset pointers no
    // longer reference; suppress it so storage only changes on real enqueues.
    assign wr_en = enq_fire & ~flush & ~rst;

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Next pointers / occupancy; flush outranks both handshakes
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq_fire) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (deq_fire) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({enq_fire, deq_fire})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data ({enq_pc, enq_instr}),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

    // Head entry, or a bubble while empty
    assign deq_pc    = empty ? '0        : rd_data[ENT_W-1 -: XLEN];
    assign deq_instr = empty ? NOP_INSTR : rd_data[ILEN-1:0];

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table with per-row expectations,
// a wrap sequence, and a randomized phase, all cross-checked every cycle
// against a queue-based scoreboard of {pc, instr} entries.
module tb_fetch_queue;
    import riscv_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             enq_valid = 1'b0;
    logic             enq_ready;
    logic [XLEN-1:0]  enq_pc = '0;
    logic [ILEN-1:0]  enq_instr = '0;
    logic             deq_valid;
    logic             deq_ready = 1'b0;
    logic [XLEN-1:0]  deq_pc;
    logic [ILEN-1:0]  deq_instr;
    logic             flush = 1'b0;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;

    always #5 clk = ~clk;

    fetch_queue #(
        .XLEN      (XLEN),
        .ILEN      (ILEN),
        .DEPTH     (DEPTH),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_pc    (enq_pc),
        .enq_instr (enq_instr),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .deq_pc    (deq_pc),
        .deq_instr (deq_instr),
        .flush     (flush),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    int           checks = 0;
    int           passed = 0;
    bit           sb_on  = 1'b0;
    fetch_entry_t sbq[$];

    typedef struct {
        logic        r;
        logic        f;
        logic        ev;
        logic [31:0] pc;
        logic        dr;
        int unsigned exp_cnt;
        logic        exp_dv;
        logic [31:0] exp_pc;
        logic        exp_er;
    } vec_t;

    vec_t vt[$];

    function automatic logic [ILEN-1:0] instr_of(input logic [XLEN-1:0] pc);
        return {~pc[15:0], pc[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // One clock: drive inputs, compare current outputs with the scoreboard,
    // update the scoreboard with what the edge should do, then cross the edge.
    task automatic cycle(input logic r, input logic f, input logic ev,
                         input logic [XLEN-1:0] pc, input logic dr, output logic acc);
        fetch_entry_t e;
        int unsigned  n;
        logic         ef, df;
        @(negedge clk);
        rst       = r;
        flush     = f;
        enq_valid = ev;
        enq_pc    = pc;
        enq_instr = instr_of(pc);
        deq_ready = dr;
        #1;
        n   = sbq.size();
        ef  = ev && (n < DEPTH);
        df  = dr && (n > 0);
        acc = ef && !r && !f;
        if (sb_on) begin
            chk("sb_count",     32'(count),     32'(n));
            chk("sb_full",      32'(full),      32'(n == DEPTH));
            chk("sb_empty",     32'(empty),     32'(n == 0));
            chk("sb_enq_ready", 32'(enq_ready), 32'(n != DEPTH));
            chk("sb_deq_valid", 32'(deq_valid), 32'(n != 0));
            chk("sb_deq_pc",    deq_pc,         (n != 0) ? sbq[0].pc : 32'h0);
            chk("sb_deq_instr", deq_instr,      (n != 0) ? sbq[0].instr : NOP_INSTR);
        end
        if (r) sb_on = 1'b1;
        if (r || f) begin
            sbq.delete();
        end else begin
            if (df) void'(sbq.pop_front());
            if (ef) begin
                e.pc    = pc;
                e.instr = instr_of(pc);
                sbq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        acc;
        logic [31:0] next_pc;

        //           r  f  ev pc           dr  cnt dv  pc           er
        vt.push_back('{1, 0, 0, 32'h0,     0,  0,  0,  32'h0,     1}); // reset
        vt.push_back('{1, 0, 0, 32'h0,     0,  0,  0,  32'h0,     1});
        vt.push_back('{0, 0, 1, 32'h100,   0,  1,  1,  32'h100,   1}); // latency
        vt.push_back('{0, 0, 0, 32'h0,     1,  0,  0,  32'h0,     1});
        vt.push_back('{0, 0, 1, 32'h0,     0,  1,  1,  32'h0,     1}); // fill
        vt.push_back('{0, 0, 1, 32'h4,     0,  2,  1,  32'h0,     1});
        vt.push_back('{0, 0, 1, 32'h8,     0,  3,  1,  32'h0,     1});
        vt.push_back('{0, 0, 1, 32'hC,     0,  4,  1,  32'h0,     0});
        vt.push_back('{0, 0, 1, 32'h10,    0,  4,  1,  32'h0,     0}); // refused
        vt.push_back('{0, 0, 0, 32'h0,     1,  3,  1,  32'h4,     1}); // drain
        vt.push_back('{0, 0, 0, 32'h0,     1,  2,  1,  32'h8,     1});
        vt.push_back('{0, 0, 0, 32'h0,     1,  1,  1,  32'hC,     1});
        vt.push_back('{0, 0, 0, 32'h0,     1,  0,  0,  32'h0,     1});
        vt.push_back('{0, 0, 0, 32'h0,     1,  0,  0,  32'h0,     1}); // deq on empty
        vt.push_back('{0, 0, 1, 32'h20,    0,  1,  1,  32'h20,    1}); // flush
        vt.push_back('{0, 0, 1, 32'h24,    0,  2,  1,  32'h20,    1});
        vt.push_back('{0, 0, 1, 32'h28,    0,  3,  1,  32'h20,    1});
        vt.push_back('{0, 1, 1, 32'h40,    1,  0,  0,  32'h0,     1});
        vt.push_back('{0, 0, 1, 32'h80,    0,  1,  1,  32'h80,    1});
        vt.push_back('{1, 1, 1, 32'h84,    1,  0,  0,  32'h0,     1}); // rst+flush
        vt.push_back('{0, 0, 1, 32'h200,   0,  1,  1,  32'h200,   1}); // full+deq
        vt.push_back('{0, 0, 1, 32'h204,   0,  2,  1,  32'h200,   1});
        vt.push_back('{0, 0, 1, 32'h208,   0,  3,  1,  32'h200,   1});
        vt.push_back('{0, 0, 1, 32'h20C,   0,  4,  1,  32'h200,   0});
        vt.push_back('{0, 0, 1, 32'h300,   1,  3,  1,  32'h204,   1});
        vt.push_back('{0, 0, 0, 32'h0,     1,  2,  1,  32'h208,   1});

        foreach (vt[i]) begin
            cycle(vt[i].r, vt[i].f, vt[i].ev, vt[i].pc, vt[i].dr, acc);
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].exp_cnt));
            chk($sformatf("vec%0d_deq_valid", i), 32'(deq_valid), 32'(vt[i].exp_dv));
            chk($sformatf("vec%0d_deq_pc", i), deq_pc, vt[i].exp_pc);
            chk($sformatf("vec%0d_enq_ready", i), 32'(enq_ready), 32'(vt[i].exp_er));
            chk($sformatf("vec%0d_deq_instr", i), deq_instr,
                vt[i].exp_dv ? instr_of(vt[i].exp_pc) : NOP_INSTR);
        end

        // Simultaneous enq/deq from count=2 across several pointer wraps
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 32'h400 + 32'(4 * i), 1'b1, acc);
            chk($sformatf("wrap%0d_count", i), 32'(count), 32'd2);
        end
        // Head after the wrap run: 0x208,0x20C then 0x400.. consumed in order
        chk("wrap_head_pc", deq_pc, 32'h420);

        // Randomized traffic; fetch holds its pc until the queue accepts it
        next_pc = 32'h1000;
        for (int i = 0; i < 400; i++) begin
            logic r, f, ev, dr;
            r  = ($urandom_range(99) < 1);
            f  = ($urandom_range(99) < 3);
            ev = ($urandom_range(99) < 70);
            dr = ($urandom_range(99) < 60);
            cycle(r, f, ev, next_pc, dr, acc);
            if (acc) next_pc = next_pc + 32'd4;
        end

        // Drain and confirm the bubble state
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, acc);
        chk("final_empty", 32'(empty), 32'd1);
        chk("final_deq_instr", deq_instr, NOP_INSTR);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_fetch_queue
